sc_stream_sequencer: RTL and testbench

- Sequences one stochastic-computing evaluation of an external SC circuit.
- Seeds and steps an 8-bit LFSR and converts NUM_IN latched binary operands into bitstreams through per-channel comparators.
- Drives those bitstreams to the circuit for a programmed stream length, counts the 1s on the circuit output, and returns the binary result over a valid/ready handshake.
- Sits between the host/test harness and the combinational SC circuit blocks.

---
 rtl/sc_stream_sequencer.sv | 170 +++++++++++++++++
 tb/tb_sc_stream_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sc_stream_sequencer
// Description : Sequences one stochastic-computing evaluation: seeds an LFSR,
//               streams comparator bits to an external SC circuit, counts the
//               1s it returns and hands the count back over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_stream_sequencer #(
    parameter int NUM_IN   = 4,
    parameter int LEN_W    = 16,
    parameter int CIRC_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            seed,
    input  logic [LEN_W-1:0]      stream_len,
    input  logic [8*NUM_IN-1:0]   in_bin,
    output logic                  busy,
    output logic [NUM_IN-1:0]     sc_bits,
    output logic                  sc_valid,
    input  logic                  circ_out,
    output logic [LEN_W-1:0]      result_count,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [7:0]            lfsr_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] c_one        = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_drain_last = LEN_W'((CIRC_LAT > 0) ? CIRC_LAT - 1 : 0);

    state_t              r_state;
    logic [7:0]          r_seed;
    logic [7:0]          r_lfsr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_sample;
    logic [LEN_W-1:0]    r_count;
    logic [8*NUM_IN-1:0] r_bin;
    logic                r_busy;
    logic                r_sc_valid;
    logic                r_result_valid;
    logic                w_cnt_en;
    logic [7:0]          w_lfsr_next;

    assign w_lfsr_next = {r_lfsr[7] ^ r_lfsr[6] ^ r_lfsr[1] ^ r_lfsr[0], r_lfsr[7:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_seed         <= 8'h00;
            r_lfsr         <= 8'h01;
            r_len          <= '0;
            r_sample       <= '0;
            r_count        <= '0;
            r_bin          <= '0;
            r_busy         <= 1'b0;
            r_sc_valid     <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            // SEED below overrides this; cnt_en is never high there anyway.
            if (w_cnt_en && circ_out)
                r_count <= r_count + c_one;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_seed  <= seed;
                        r_len   <= stream_len;
                        r_bin   <= in_bin;
                        r_busy  <= 1'b1;
                        r_state <= S_SEED;
                    end
                end
                S_SEED: begin
                    r_lfsr   <= (r_seed == 8'h00) ? 8'h01 : r_seed;
                    r_sample <= '0;
                    r_count  <= '0;
                    if (r_len == '0) begin
                        r_state        <= S_DONE;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_state    <= S_RUN;
                        r_sc_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_sample == r_len - c_one) begin
                        r_sample   <= '0;
                        r_sc_valid <= 1'b0;
                        if (CIRC_LAT > 0) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state        <= S_DONE;
                            r_result_valid <= 1'b1;
                        end
                    end else begin
                        r_sample <= r_sample + c_one;
                    end
                end
                S_DRAIN: begin
                    if (r_sample == c_drain_last) begin
                        r_sample       <= '0;
                        r_state        <= S_DONE;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_sample <= r_sample + c_one;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Count enable tracks sc_valid through the circuit's pipeline depth.
    generate
        if (CIRC_LAT == 0) begin : g_lat0
            assign w_cnt_en = r_sc_valid;
        end else begin : g_latn
            logic [CIRC_LAT-1:0] r_pipe;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= r_sc_valid;
                    for (int k = 1; k < CIRC_LAT; k++)
                        r_pipe[k] <= r_pipe[k-1];
                end
            end
            assign w_cnt_en = r_pipe[CIRC_LAT-1];
        end
    endgenerate

    // Channel i compares the inverted, i-bit rotated LFSR word against b_i.
    logic [15:0] w_lfsr_dbl;
    assign w_lfsr_dbl = {r_lfsr, r_lfsr};

    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
            logic [7:0] w_rnd;
            logic [7:0] w_rnd_n;
            assign w_rnd      = w_lfsr_dbl[15-i -: 8];
            assign w_rnd_n    = ~w_rnd;
            assign sc_bits[i] = r_sc_valid & (w_rnd_n < r_bin[8*i +: 8]);
        end
    endgenerate

    assign busy         = r_busy;
    assign sc_valid     = r_sc_valid;
    assign result_valid = r_result_valid;
    assign result_count = r_count;
    assign lfsr_state   = r_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_sc_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_stream_sequencer
// Description : Directed bench for sc_stream_sequencer, one instance with
//               CIRC_LAT=0 and one with CIRC_LAT=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start2;
    logic [7:0]  seed;
    logic [15:0] len;
    logic [31:0] in_bin;
    logic        ready;
    logic [1:0]  mode;
    logic        circ2;

    logic        busy0, scv0, rv0, circ_out0;
    logic [3:0]  scb0;
    logic [15:0] cnt0;
    logic [7:0]  lfsr0;
    logic        busy2, scv2, rv2;
    logic [3:0]  scb2;
    logic [15:0] cnt2;
    logic [7:0]  lfsr2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign circ_out0 = (mode == 2'd0) ? scb0[0] : (mode == 2'd1) ? &scb0 : 1'b1;

    sc_stream_sequencer #(.NUM_IN(4), .LEN_W(16), .CIRC_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed), .stream_len(len),
        .in_bin(in_bin), .busy(busy0), .sc_bits(scb0), .sc_valid(scv0),
        .circ_out(circ_out0), .result_count(cnt0), .result_valid(rv0),
        .result_ready(ready), .lfsr_state(lfsr0)
    );

    sc_stream_sequencer #(.NUM_IN(4), .LEN_W(16), .CIRC_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed), .stream_len(len),
        .in_bin(in_bin), .busy(busy2), .sc_bits(scb2), .sc_valid(scv2),
        .circ_out(circ2), .result_count(cnt2), .result_valid(rv2),
        .result_ready(ready), .lfsr_state(lfsr2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[7] ^ s[6] ^ s[1] ^ s[0], s[7:1]};
    endfunction

    // Count of cycles on which every channel bit is 1, all channels sharing b.
    function automatic int golden_and(input logic [7:0] sd, input int n, input logic [7:0] b);
        logic [7:0] s, r, nr;
        logic all1;
        int cnt;
        s = (sd == 8'h00) ? 8'h01 : sd;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            all1 = 1'b1;
            for (int i = 0; i < 4; i++) begin
                r  = (s << i) | (s >> (8 - i));
                nr = ~r;
                if (!(nr < b)) all1 = 1'b0;
            end
            if (all1) cnt++;
            s = step(s);
        end
        return cnt;
    endfunction

    // len=3, b0=80: LFSR 01,80,C0 gives channel-0 bits 0,1,1 -> count 2.
    task automatic run3(input string tag, input logic [7:0] sd);
        seed = sd; len = 16'd3; in_bin = 32'h0000_0080; mode = 2'd0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        check({tag, " seed busy"}, busy0, 1);
        check({tag, " seed scv"}, scv0, 0);
        tick();
        check({tag, " run1 scv"}, scv0, 1);
        check({tag, " run1 lfsr"}, lfsr0, 8'h01);
        check({tag, " run1 bit"}, scb0[0], 0);
        tick();
        check({tag, " run2 lfsr"}, lfsr0, 8'h80);
        check({tag, " run2 bit"}, scb0[0], 1);
        tick();
        check({tag, " run3 scv"}, scv0, 1);
        check({tag, " run3 lfsr"}, lfsr0, 8'hC0);
        check({tag, " run3 bit"}, scb0[0], 1);
        tick();
        check({tag, " done scv"}, scv0, 0);
        check({tag, " done bits"}, scb0, 0);
        check({tag, " done rv"}, rv0, 1);
        check({tag, " done cnt"}, cnt0, 2);
        ready = 1'b1; tick(); ready = 1'b0;
        check({tag, " rv clear"}, rv0, 0);
        check({tag, " idle busy"}, busy0, 0);
    endtask

    task automatic run0(input string tag, input logic [7:0] sd, input logic [15:0] ln,
                        input logic [31:0] b, input logic [1:0] md,
                        input logic [15:0] exp_cnt, input int pulse_at);
        int n;
        seed = sd; len = ln; in_bin = b; mode = md;
        start0 = 1'b1; tick(); start0 = 1'b0;
        n = 0;
        while (rv0 !== 1'b1 && n < 400) begin
            start0 = (pulse_at >= 0) && (n == pulse_at || n == pulse_at + 50);
            if (start0) begin
                seed = ~sd; in_bin = ~b; len = 16'd7;
            end
            tick();
            n++;
        end
        start0 = 1'b0;
        check({tag, " cycles"}, n, ln + 1);
        check({tag, " count"}, cnt0, exp_cnt);
        ready = 1'b1; tick(); ready = 1'b0;
        check({tag, " rv clear"}, rv0, 0);
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; seed = 8'h00; len = 16'd0;
        in_bin = 32'h0; ready = 1'b0; mode = 2'd0; circ2 = 1'b1;
        tick(); tick(); tick();
        check("rst busy", busy0, 0);
        check("rst scv", scv0, 0);
        check("rst bits", scb0, 0);
        check("rst rv", rv0, 0);
        check("rst cnt", cnt0, 0);
        check("rst lfsr", lfsr0, 8'h01);
        check("rst lfsr2", lfsr2, 8'h01);
        check("rst busy2", busy2, 0);
        rst_n = 1'b1;
        tick();

        // Abort in the middle of a long run.
        seed = 8'h37; len = 16'd100; in_bin = 32'hFFFF_FFFF; mode = 2'd2;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("midrun scv", scv0, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("abort busy", busy0, 0);
        check("abort scv", scv0, 0);
        check("abort rv", rv0, 0);
        check("abort lfsr", lfsr0, 8'h01);
        tick();
        check("abort stays idle", rv0, 0);

        run3("seed01", 8'h01);
        run3("seed00", 8'h00);

        // len=0 goes straight to DONE; start together with ready in DONE is not taken.
        seed = 8'h01; len = 16'd0; mode = 2'd2;
        start0 = 1'b1; tick(); start0 = 1'b0;
        check("len0 seed scv", scv0, 0);
        tick();
        check("len0 rv", rv0, 1);
        check("len0 cnt", cnt0, 0);
        check("len0 scv", scv0, 0);
        start0 = 1'b1; ready = 1'b1; tick(); ready = 1'b0;
        check("hs idle busy", busy0, 0);
        check("hs rv", rv0, 0);
        tick(); start0 = 1'b0;
        check("restart busy", busy0, 1);
        tick();
        check("restart rv", rv0, 1);
        ready = 1'b1; tick(); ready = 1'b0;
        check("restart rv clear", rv0, 0);

        run0("b00", 8'h3C, 16'd255, 32'h0000_0000, 2'd0, 16'd0, -1);
        run0("bFF", 8'h3C, 16'd255, 32'h0000_00FF, 2'd0, 16'd255, -1);

        // CIRC_LAT=2 instance, circuit output tied high.
        seed = 8'h05; len = 16'd10; circ2 = 1'b1;
        start2 = 1'b1; tick(); start2 = 1'b0;
        tick();
        check("lat2 run first scv", scv2, 1);
        for (int i = 0; i < 9; i++) tick();
        check("lat2 run last scv", scv2, 1);
        tick();
        check("lat2 drain1 scv", scv2, 0);
        check("lat2 drain1 busy", busy2, 1);
        check("lat2 drain1 rv", rv2, 0);
        tick();
        check("lat2 drain2 rv", rv2, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("lat2 hold rv", rv2, 1);
            check("lat2 hold cnt", cnt2, 10);
            tick();
        end
        check("lat2 hold rv6", rv2, 1);
        ready = 1'b1; tick(); ready = 1'b0;
        check("lat2 rv clear", rv2, 0);
        check("lat2 busy clear", busy2, 0);

        // AND of four channels at b=80, with ignored start pulses and input churn.
        run0("and80", 8'h5A, 16'd200, 32'h8080_8080, 2'd1,
             16'(golden_and(8'h5A, 200, 8'h80)), 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
